// File: rtl/l1_dcache_param.sv
// Direct-mapped, write-through L1 data cache of single-word lines with load miss fill and per-lane store merge.
// Latency: load hits complete combinationally; misses and stores hold stall until mem_ack, with one memory transaction outstanding.
module l1_dcache_param #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        mask,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int TAG_W = ADDR_W - 2 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  generate
    if (TAG_W < 1) begin : g_bad_tag_w
      $error("l1_dcache_param: ADDR_W-2-INDEX_W must be at least 1");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WTHRU = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_off;
  logic [2:0]         r_mask;
  logic [31:0]        r_wdata;

  logic [INDEX_W-1:0] in_index;
  logic [TAG_W-1:0]   in_tag;
  logic [1:0]         in_off;
  logic               in_hit, r_hit, ld_ok, st_ok;

  logic               capture, flush_all, line_we, hit_inc, miss_inc;
  logic [31:0]        line_dat;

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] off,
                                          input logic [2:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (m)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b010:  extract = d;
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] off, input logic [2:0] m);
    case (m)
      3'b000:  byte_en = 4'b0001 << off;
      3'b001:  byte_en = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] w, input logic [2:0] m);
    case (m)
      3'b000:  replicate = {4{w[7:0]}};
      3'b001:  replicate = {2{w[15:0]}};
      default: replicate = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      merge[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
    end
  endfunction

  assign in_index = addr[INDEX_W+1:2];
  assign in_tag   = addr[ADDR_W-1:INDEX_W+2];
  assign in_off   = addr[1:0];
  assign in_hit   = valid_q[in_index] && (tag_mem[in_index] == in_tag);
  assign r_hit    = valid_q[r_index] && (tag_mem[r_index] == r_tag);
  assign ld_ok    = mask inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign st_ok    = mask inside {3'b000, 3'b001, 3'b010};

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    rdata     = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'd0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    capture   = 1'b0;
    flush_all = 1'b0;
    line_we   = 1'b0;
    line_dat  = 32'd0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            stall     = 1'b1;
            flush_all = 1'b1;
          end else if (wr_en) begin
            // A store with a load-only mask code is dropped, even if rd_en is also high.
            if (st_ok) begin
              stall    = 1'b1;
              capture  = 1'b1;
              miss_inc = !in_hit;
              state_d  = WTHRU;
            end
          end else if (rd_en && ld_ok) begin
            if (in_hit) begin
              rdata   = extract(data_mem[in_index], in_off, mask);
              hit_inc = 1'b1;
            end else begin
              stall    = 1'b1;
              capture  = 1'b1;
              miss_inc = 1'b1;
              state_d  = FILL;
            end
          end
        end
        FILL: begin
          mem_req  = 1'b1;
          mem_be   = 4'hF;
          mem_addr = {r_tag, r_index};
          stall    = !mem_ack;
          if (mem_ack) begin
            rdata    = extract(mem_rdata, r_off, r_mask);
            line_we  = 1'b1;
            line_dat = mem_rdata;
            state_d  = IDLE;
          end
        end
        WTHRU: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_be    = byte_en(r_off, r_mask);
          mem_addr  = {r_tag, r_index};
          mem_wdata = replicate(r_wdata, r_mask);
          stall     = !mem_ack;
          if (mem_ack) begin
            state_d = IDLE;
            if (r_hit) begin
              line_we  = 1'b1;
              line_dat = merge(data_mem[r_index], mem_wdata, mem_be);
              hit_inc  = 1'b1;
            end else if (r_mask == 3'b010) begin
              // Only a full-word store can allocate; partial misses bypass the cache.
              line_we  = 1'b1;
              line_dat = mem_wdata;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
      r_index  <= '0;
      r_tag    <= '0;
      r_off    <= 2'd0;
      r_mask   <= 3'd0;
      r_wdata  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        r_index <= in_index;
        r_tag   <= in_tag;
        r_off   <= in_off;
        r_mask  <= mask;
        r_wdata <= wdata;
      end
      if (flush_all) begin
        valid_q <= '0;
      end else if (line_we) begin
        valid_q[r_index] <= 1'b1;
      end
      if (hit_inc && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if (miss_inc && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[r_index]  <= r_tag;
      data_mem[r_index] <= line_dat;
    end
  end

endmodule

// File: tb/tb_l1_dcache_param.sv
// Bench for l1_dcache_param: table of load/store vectors with a queue of expected load results, plus flush and mid-fill reset sequences.
module tb_l1_dcache_param;

  logic        clk;
  logic        reset;
  logic        rd_en, wr_en, flush;
  logic [2:0]  mask;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  l1_dcache_param #(.ADDR_W(10), .INDEX_W(6)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .mask(mask),
    .addr(addr), .wdata(wdata), .flush(flush), .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_LD   = 0;
  localparam int K_ST   = 1;
  localparam int K_NONE = 2;
  localparam int K_BOTH = 3;

  typedef struct {
    int          kind;
    logic [2:0]  mask;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        miss;
    int          lat;
    logic [31:0] mem_rd;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    int          exp_hit;
    int          exp_miss;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(int kind, logic [2:0] m, logic [9:0] a, logic [31:0] w,
                              logic miss, int lat, logic [31:0] mrd, logic [31:0] er,
                              logic [7:0] ema, logic [3:0] ebe, logic [31:0] emw,
                              int eh, int em);
    vec_t v;
    v.kind = kind; v.mask = m; v.addr = a; v.wdata = w; v.miss = miss; v.lat = lat;
    v.mem_rd = mrd; v.exp_rdata = er; v.exp_maddr = ema; v.exp_be = ebe;
    v.exp_mwdata = emw; v.exp_hit = eh; v.exp_miss = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic is_st;
    is_st = (v.kind == K_ST || v.kind == K_BOTH);
    rd_en = (v.kind == K_LD || v.kind == K_NONE || v.kind == K_BOTH);
    wr_en = is_st;
    mask  = v.mask;
    addr  = v.addr;
    wdata = v.wdata;
    if (!is_st) exp_q.push_back(v.exp_rdata);
    @(negedge clk);
    chk($sformatf("v%0d stall_issue", n), 32'(stall), 32'(v.miss));
    if (!v.miss && exp_q.size() > 0) chk($sformatf("v%0d rdata_hit", n), rdata, exp_q.pop_front());
    next_cycle();
    if (v.miss) begin
      for (int c = 1; c <= v.lat; c++) begin
        if (c == v.lat) begin
          mem_ack   = 1'b1;
          mem_rdata = v.mem_rd;
        end
        @(negedge clk);
        if (c == 1) begin
          chk($sformatf("v%0d mem_req", n), 32'(mem_req), 32'd1);
          chk($sformatf("v%0d mem_we", n), 32'(mem_we), 32'(is_st));
          chk($sformatf("v%0d mem_addr", n), 32'(mem_addr), 32'(v.exp_maddr));
          chk($sformatf("v%0d mem_be", n), 32'(mem_be), 32'(v.exp_be));
          if (is_st) chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.exp_mwdata);
        end
        if (c < v.lat) begin
          chk($sformatf("v%0d stall_wait", n), 32'(stall), 32'd1);
          chk($sformatf("v%0d rdata_wait", n), rdata, 32'd0);
        end else begin
          chk($sformatf("v%0d stall_ack", n), 32'(stall), 32'd0);
          if (!is_st && exp_q.size() > 0) chk($sformatf("v%0d rdata_fill", n), rdata, exp_q.pop_front());
          else chk($sformatf("v%0d rdata_store", n), rdata, 32'd0);
        end
        next_cycle();
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    mask  = 3'd0;
    @(negedge clk);
    chk($sformatf("v%0d hit_cnt", n), 32'(hit_cnt), 32'(v.exp_hit));
    chk($sformatf("v%0d miss_cnt", n), 32'(miss_cnt), 32'(v.exp_miss));
    chk($sformatf("v%0d mem_req_idle", n), 32'(mem_req), 32'd0);
    next_cycle();
  endtask

  initial begin
    tbl[0]  = mk(K_LD,   3'b010, 10'h104, 32'h0,        1, 3, 32'h8899AABB, 32'h8899AABB, 8'h41, 4'hF,    32'h0,        0,  1);
    tbl[1]  = mk(K_LD,   3'b000, 10'h107, 32'h0,        0, 0, 32'h0,        32'hFFFFFF88, 8'h0,  4'h0,    32'h0,        1,  1);
    tbl[2]  = mk(K_LD,   3'b100, 10'h107, 32'h0,        0, 0, 32'h0,        32'h00000088, 8'h0,  4'h0,    32'h0,        2,  1);
    tbl[3]  = mk(K_ST,   3'b001, 10'h106, 32'h1234,     1, 1, 32'h0,        32'h0,        8'h41, 4'b1100, 32'h12341234, 3,  1);
    tbl[4]  = mk(K_LD,   3'b010, 10'h104, 32'h0,        0, 0, 32'h0,        32'h1234AABB, 8'h0,  4'h0,    32'h0,        4,  1);
    tbl[5]  = mk(K_ST,   3'b000, 10'h204, 32'h55,       1, 2, 32'h0,        32'h0,        8'h81, 4'b0001, 32'h55555555, 4,  2);
    tbl[6]  = mk(K_LD,   3'b010, 10'h104, 32'h0,        0, 0, 32'h0,        32'h1234AABB, 8'h0,  4'h0,    32'h0,        5,  2);
    tbl[7]  = mk(K_LD,   3'b001, 10'h106, 32'h0,        0, 0, 32'h0,        32'h00001234, 8'h0,  4'h0,    32'h0,        6,  2);
    tbl[8]  = mk(K_LD,   3'b101, 10'h104, 32'h0,        0, 0, 32'h0,        32'h0000AABB, 8'h0,  4'h0,    32'h0,        7,  2);
    tbl[9]  = mk(K_LD,   3'b001, 10'h104, 32'h0,        0, 0, 32'h0,        32'hFFFFAABB, 8'h0,  4'h0,    32'h0,        8,  2);
    tbl[10] = mk(K_NONE, 3'b011, 10'h104, 32'h0,        0, 0, 32'h0,        32'h0,        8'h0,  4'h0,    32'h0,        8,  2);
    tbl[11] = mk(K_ST,   3'b010, 10'h208, 32'hDEADBEEF, 1, 1, 32'h0,        32'h0,        8'h82, 4'hF,    32'hDEADBEEF, 8,  3);
    tbl[12] = mk(K_LD,   3'b010, 10'h208, 32'h0,        0, 0, 32'h0,        32'hDEADBEEF, 8'h0,  4'h0,    32'h0,        9,  3);
    tbl[13] = mk(K_LD,   3'b000, 10'h209, 32'h0,        0, 0, 32'h0,        32'hFFFFFFBE, 8'h0,  4'h0,    32'h0,        10, 3);
    tbl[14] = mk(K_ST,   3'b000, 10'h20A, 32'h77,       1, 1, 32'h0,        32'h0,        8'h82, 4'b0100, 32'h77777777, 11, 3);
    tbl[15] = mk(K_LD,   3'b010, 10'h208, 32'h0,        0, 0, 32'h0,        32'hDE77BEEF, 8'h0,  4'h0,    32'h0,        12, 3);
    tbl[16] = mk(K_LD,   3'b101, 10'h20A, 32'h0,        0, 0, 32'h0,        32'h0000DE77, 8'h0,  4'h0,    32'h0,        13, 3);
    tbl[17] = mk(K_LD,   3'b000, 10'h30F, 32'h0,        1, 2, 32'h80112233, 32'hFFFFFF80, 8'hC3, 4'hF,    32'h0,        13, 4);
    tbl[18] = mk(K_LD,   3'b100, 10'h30C, 32'h0,        0, 0, 32'h0,        32'h00000033, 8'h0,  4'h0,    32'h0,        14, 4);
    tbl[19] = mk(K_BOTH, 3'b001, 10'h10C, 32'hCAFE,     1, 2, 32'h0,        32'h0,        8'h43, 4'b0011, 32'hCAFECAFE, 14, 5);
    tbl[20] = mk(K_LD,   3'b010, 10'h30C, 32'h0,        0, 0, 32'h0,        32'h80112233, 8'h0,  4'h0,    32'h0,        15, 5);

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0; mask = 3'd0;
    addr = 10'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;

    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst hit_cnt", 32'(hit_cnt), 32'd0);
    chk("post_rst miss_cnt", 32'(miss_cnt), 32'd0);
    chk("post_rst stall", 32'(stall), 32'd0);
    next_cycle();

    for (int i = 0; i < 21; i++) run_vec(tbl[i], i);

    // Flush in IDLE stalls for one cycle and forces the next load to miss.
    flush = 1'b1;
    rd_en = 1'b1; mask = 3'b010; addr = 10'h104;
    @(negedge clk);
    chk("flush stall", 32'(stall), 32'd1);
    chk("flush mem_req", 32'(mem_req), 32'd0);
    chk("flush hit_cnt_hold", 32'(hit_cnt), 32'd15);
    next_cycle();
    flush = 1'b0;
    run_vec(mk(K_LD, 3'b010, 10'h104, 32'h0, 1, 2, 32'h1234AABB, 32'h1234AABB,
               8'h41, 4'hF, 32'h0, 15, 6), 100);

    // Reset two cycles into a fill, then a late ack that must be ignored.
    rd_en = 1'b1; mask = 3'b010; addr = 10'h3F0;
    @(negedge clk);
    chk("rfill stall_issue", 32'(stall), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("rfill mem_req_c1", 32'(mem_req), 32'd1);
    chk("rfill mem_addr_c1", 32'(mem_addr), 32'hFC);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rfill in_rst mem_req", 32'(mem_req), 32'd0);
    chk("rfill in_rst stall", 32'(stall), 32'd0);
    next_cycle();
    reset = 1'b0; rd_en = 1'b0; mask = 3'd0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rfill late_ack mem_req", 32'(mem_req), 32'd0);
    chk("rfill late_ack stall", 32'(stall), 32'd0);
    chk("rfill late_ack rdata", rdata, 32'd0);
    next_cycle();
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    chk("rfill hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rfill miss_cnt", 32'(miss_cnt), 32'd0);
    next_cycle();
    run_vec(mk(K_LD, 3'b010, 10'h3F0, 32'h0, 1, 1, 32'h0BADF00D, 32'h0BADF00D,
               8'hFC, 4'hF, 32'h0, 0, 1), 101);
    run_vec(mk(K_LD, 3'b010, 10'h104, 32'h0, 1, 1, 32'h11223344, 32'h11223344,
               8'h41, 4'hF, 32'h0, 0, 2), 102);

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_dcache_param.md
L1_DCACHE_PARAM -- requirements
Module: l1_dcache_param

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10: byte-address width.
REQ-002 SHALL provide parameter INDEX_W, default 6: line index width, giving 2**INDEX_W lines of one 32-bit word each.
REQ-003 SHALL derive TAG_W = ADDR_W-2-INDEX_W; elaboration SHALL fail if TAG_W < 1.
REQ-004 SHALL provide ports (name, direction, width, meaning):
- clk in 1: single clock, all state on rising edge.
- reset in 1: synchronous, active-high.
- rd_en in 1: load request.
- wr_en in 1: store request.
- mask in 3: 000 LB, 001 LH, 010 LW/SW, 100 LBU, 101 LHU; stores use SB/SH/SW for 000/001/010.
- addr in ADDR_W: byte address.
- wdata in 32: store data, right-aligned.
- flush in 1: invalidate all lines.
- rdata out 32: load result.
- stall out 1: request not complete this cycle.
- mem_req out 1, mem_we out 1, mem_addr out ADDR_W-2 (word address), mem_be out 4, mem_wdata out 32: memory request.
- mem_rdata in 32, mem_ack in 1: memory response.
- hit_cnt out 16, miss_cnt out 16: statistics.

Function
REQ-005 SHALL be direct-mapped: index = addr[INDEX_W+1:2], tag = addr[ADDR_W-1:INDEX_W+2], byte offset = addr[1:0]; LH/SH ignore addr[0]; LW/SW ignore addr[1:0].
REQ-006 SHALL use FSM states IDLE, FILL, WTHRU; one memory transaction outstanding at most.
REQ-007 wr_en SHALL take priority over rd_en when both are high; an invalid mask code SHALL be treated as no request (stall=0, rdata=0).
REQ-008 Load hit in IDLE: rdata = extracted, sign/zero-extended data in the same cycle, stall=0, no memory access.
REQ-009 Load miss in IDLE:
- stall=1.
- Index, tag, offset and mask are registered; IDLE->FILL.
REQ-010 In FILL:
- mem_req=1, mem_we=0, mem_be=4'hF, mem_addr = registered word address; held constant until mem_ack.
- stall=1 until the mem_ack cycle.
REQ-011 On mem_ack in FILL:
- Line is written {valid=1, tag, mem_rdata} at the edge.
- rdata = extract(mem_rdata) with stall=0 in that same cycle; FILL->IDLE.
REQ-012 Store in IDLE:
- stall=1; registers request; IDLE->WTHRU (write-through, every store reaches memory).
REQ-013 In WTHRU:
- mem_req=1, mem_we=1.
- mem_be = one-hot byte (SB), 2'b11 pair (SH), 4'hF (SW).
- mem_wdata = wdata replicated into the enabled lanes; held until mem_ack.
REQ-014 On mem_ack in WTHRU:
- stall=0; WTHRU->IDLE.
- On a tag hit, the line is byte-merged with the new data.
- On a miss, SW allocates {valid=1, tag, wdata} and SB/SH leave the cache unchanged.
REQ-015 Upstream SHALL hold addr, wdata, mask, rd_en and wr_en stable while stall=1; the block uses the registered copies in FILL and WTHRU.
REQ-016 mem_ack outside FILL or WTHRU SHALL be ignored.
REQ-017 flush in IDLE SHALL take priority over rd_en and wr_en: stall=1 that cycle and all valid bits clear at the edge; flush in FILL or WTHRU SHALL be ignored.
REQ-018 hit_cnt SHALL increment once per load hit (REQ-008) and per store tag hit at completion.
REQ-019 miss_cnt SHALL increment once on entry to FILL or on a store tag miss at entry to WTHRU; both counters saturate at 16'hFFFF.
REQ-020 rdata SHALL be 0 whenever no load is completing.

Reset
REQ-021 reset SHALL force, at the next edge:
- state=IDLE; all valid bits=0; hit_cnt=miss_cnt=0.
- Registered request cleared.
REQ-022 While reset is high, outputs SHALL be stall=0, rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-023 Reset asserted in FILL or WTHRU SHALL abandon the transaction (mem_req low next cycle, no line update), and a late mem_ack SHALL be ignored.
REQ-024 Data array contents need not be reset.

Verification
REQ-025 After reset, LW addr=0x104 -> stall=1, FILL, mem_addr=0x041; mem_ack after 3 cycles with mem_rdata=0x8899AABB -> rdata=0x8899AABB in the ack cycle; miss_cnt=1.
REQ-026 Repeat LB addr=0x107 then LBU addr=0x107 -> each hit, stall=0, rdata=0xFFFFFF88 and 0x00000088; hit_cnt=2.
REQ-027 SH addr=0x106 wdata=0x1234 -> WTHRU, mem_be=4'b1100, mem_wdata=0x12341234; after ack, LW 0x104 hits with 0x1234AABB.
REQ-028 SB to tag-miss address 0x204 (same index) -> memory written, cache unchanged; following LW 0x104 still hits; miss_cnt increments.
REQ-029 flush in IDLE then LW 0x104 -> miss, FILL entered.
REQ-030 reset asserted two cycles into FILL -> mem_req=0 next cycle, a subsequent mem_ack is ignored, and LW 0x104 then misses.
